// File: rtl/reg_file_param.sv
// reg_file_param: 2R/1W register file with pending bits, clear engine, optional bypass (RF_BYPASS_EN)
module reg_file_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [AW-1:0]    DR,
  input  logic             LD_REG,
  input  logic [WIDTH-1:0] Data_In,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1_Out,
  output logic [WIDTH-1:0] SR2_Out,
  input  logic             Lock_Set,
  input  logic [AW-1:0]    Lock_Addr,
  output logic             SR1_Pending,
  output logic             SR2_Pending,
  input  logic             Clear_Start,
  output logic             Clear_Busy,
  output logic             Clear_Done
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] idx;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic idle;
  assign idle = state == IDLE;
  assign Clear_Busy = state == CLEAR;
  assign Clear_Done = state == DONE;
  always_comb begin
    state_nx = IDLE;
    if (idle) state_nx = Clear_Start ? CLEAR : IDLE;
    else if (state == CLEAR) state_nx = idx == AW'(DEPTH - 1) ? DONE : CLEAR;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      idx <= '0;
      pend <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (Clear_Busy) begin
        regs[idx] <= '0;
        pend[idx] <= 1'b0;
        idx <= idx + AW'(1);
      end else if (idle) begin
        if (Clear_Start) idx <= '0;
        if (LD_REG) begin
          regs[DR] <= Data_In;
          pend[DR] <= 1'b0;
        end
        // set after the write-clear so a same-cycle lock marks a new outstanding load
        if (Lock_Set) pend[Lock_Addr] <= 1'b1;
      end
    end
  end
`ifdef RF_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = LD_REG && idle && SR1 == DR;
  assign byp2 = LD_REG && idle && SR2 == DR;
  assign SR1_Out = byp1 ? Data_In : regs[SR1];
  assign SR2_Out = byp2 ? Data_In : regs[SR2];
  assign SR1_Pending = byp1 ? Lock_Set && Lock_Addr == SR1 : pend[SR1];
  assign SR2_Pending = byp2 ? Lock_Set && Lock_Addr == SR2 : pend[SR2];
`else
  assign SR1_Out = regs[SR1];
  assign SR2_Out = regs[SR2];
  assign SR1_Pending = pend[SR1];
  assign SR2_Pending = pend[SR2];
`endif
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of reg_file_param at 16x8 and 32x16
module tb_reg_file_param;
  logic Clk = 1'b0, Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  logic [2:0] DR, SR1, SR2, Lock_Addr;
  logic LD_REG, Lock_Set, Clear_Start;
  logic [15:0] Data_In, SR1_Out, SR2_Out;
  logic SR1_Pending, SR2_Pending, Clear_Busy, Clear_Done;
  logic [3:0] b_DR, b_SR1, b_SR2, b_Lock_Addr;
  logic b_LD_REG, b_Lock_Set, b_Clear_Start;
  logic [31:0] b_Data_In, b_SR1_Out, b_SR2_Out;
  logic b_SR1_Pending, b_SR2_Pending, b_Clear_Busy, b_Clear_Done;
  int total = 0, passed = 0;
  reg_file_param dut (
    .Clk(Clk), .Reset_n(Reset_n), .DR(DR), .LD_REG(LD_REG), .Data_In(Data_In),
    .SR1(SR1), .SR2(SR2), .SR1_Out(SR1_Out), .SR2_Out(SR2_Out),
    .Lock_Set(Lock_Set), .Lock_Addr(Lock_Addr), .SR1_Pending(SR1_Pending),
    .SR2_Pending(SR2_Pending), .Clear_Start(Clear_Start), .Clear_Busy(Clear_Busy),
    .Clear_Done(Clear_Done));
  reg_file_param #(.WIDTH(32), .DEPTH(16)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .DR(b_DR), .LD_REG(b_LD_REG), .Data_In(b_Data_In),
    .SR1(b_SR1), .SR2(b_SR2), .SR1_Out(b_SR1_Out), .SR2_Out(b_SR2_Out),
    .Lock_Set(b_Lock_Set), .Lock_Addr(b_Lock_Addr), .SR1_Pending(b_SR1_Pending),
    .SR2_Pending(b_SR2_Pending), .Clear_Start(b_Clear_Start), .Clear_Busy(b_Clear_Busy),
    .Clear_Done(b_Clear_Done));
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    DR = a; Data_In = d; LD_REG = 1'b1;
    tick();
    LD_REG = 1'b0;
  endtask
  initial begin
    {DR, LD_REG, Data_In, Lock_Set, Lock_Addr, Clear_Start} = '0;
    {b_DR, b_SR1, b_SR2, b_LD_REG, b_Data_In, b_Lock_Set, b_Lock_Addr, b_Clear_Start} = '0;
    SR1 = 3'd3; SR2 = 3'd5;
    #2;
    chk("rst_sr1", SR1_Out, 0);
    chk("rst_sr2", SR2_Out, 0);
    chk("rst_pend", {SR1_Pending, SR2_Pending}, 0);
    chk("rst_busy", {Clear_Busy, Clear_Done}, 0);
    tick();
    Reset_n = 1'b1;
    tick();
    DR = 3'd2; Data_In = 16'hBEEF; LD_REG = 1'b1; SR1 = 3'd2;
    #1;
`ifdef RF_BYPASS_EN
    chk("same_cycle_read", SR1_Out, 16'hBEEF);
`else
    chk("same_cycle_read", SR1_Out, 16'h0000);
`endif
    tick();
    wr(3'd7, 16'h1234);
    SR1 = 3'd2; SR2 = 3'd7;
    #1;
    chk("read_r2", SR1_Out, 16'hBEEF);
    chk("read_r7", SR2_Out, 16'h1234);
    Lock_Set = 1'b1; Lock_Addr = 3'd4;
    tick();
    Lock_Set = 1'b0; SR1 = 3'd4;
    #1;
    chk("lock_r4", SR1_Pending, 1);
    wr(3'd4, 16'h00AA);
    chk("wr_unlock", SR1_Pending, 0);
    chk("wr_r4", SR1_Out, 16'h00AA);
    Lock_Set = 1'b1;
    wr(3'd4, 16'h0055);
    Lock_Set = 1'b0;
    #1;
    chk("lockwr_data", SR1_Out, 16'h0055);
    chk("lockwr_pend", SR1_Pending, 1);
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * (i + 1)));
    Clear_Start = 1'b1;
    tick();
    Clear_Start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        SR1 = 3'd0; SR2 = 3'd7; DR = 3'd1; Data_In = 16'hFFFF; LD_REG = 1'b1;
        #1;
        chk("mid_r0", SR1_Out, 0);
        chk("mid_r7", SR2_Out, 16'h8888);
      end
      chk("busy", {Clear_Busy, Clear_Done}, 2'b10);
      tick();
      LD_REG = 1'b0;
    end
    chk("done_pulse", {Clear_Busy, Clear_Done}, 2'b01);
    tick();
    chk("done_end", {Clear_Busy, Clear_Done}, 2'b00);
    SR1 = 3'd1; SR2 = 3'd4;
    #1;
    chk("r1_dropped", SR1_Out, 0);
    chk("r4_cleared", {SR2_Out, 15'd0, SR2_Pending}, 0);
    wr(3'd6, 16'h6666);
    Clear_Start = 1'b1;
    tick();
    Clear_Start = 1'b0;
    repeat (3) tick();
    SR1 = 3'd6;
    #1;
    chk("pre_abort_r6", SR1_Out, 16'h6666);
    Reset_n = 1'b0;
    #1;
    chk("abort_r6", SR1_Out, 0);
    chk("abort_flags", {Clear_Busy, Clear_Done}, 0);
    repeat (2) begin
      tick();
      chk("abort_no_done", Clear_Done, 0);
    end
    Reset_n = 1'b1;
    tick();
    chk("post_rst_idle", {Clear_Busy, Clear_Done}, 0);
    wr(3'd5, 16'h0F0F);
    SR2 = 3'd5;
    #1;
    chk("post_rst_wr", SR2_Out, 16'h0F0F);
    b_DR = 4'd15; b_Data_In = 32'hDEADBEEF; b_LD_REG = 1'b1;
    tick();
    b_LD_REG = 1'b0; b_SR1 = 4'd15;
    #1;
    chk("b_r15", b_SR1_Out, 32'hDEADBEEF);
    b_Clear_Start = 1'b1;
    tick();
    b_Clear_Start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("b_busy", {b_Clear_Busy, b_Clear_Done}, 2'b10);
      tick();
    end
    chk("b_done", {b_Clear_Busy, b_Clear_Done}, 2'b01);
    tick();
    chk("b_idle", {b_Clear_Busy, b_Clear_Done}, 2'b00);
    chk("b_r15_cleared", b_SR1_Out, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
